sample_fifo_feeder: RTL and testbench

//   Elastic sample buffer upstream of the I2S serializer. Accepts 24-bit samples from a producer
//   (tone generator, filter chain) in clk_50 via valid/ready and stores them in a FIFO.

---
 rtl/sample_fifo_feeder.sv | 129 ++++++++++++
 tb/tb_sample_fifo_feeder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sample_fifo_feeder.sv
// sample_fifo_feeder
//   Elastic sample buffer in front of the I2S serializer. A producer pushes DATA_W-bit samples
//   over valid/ready into a 2**DEPTH_LOG2-entry FIFO. Each falling edge of daclrck (the start of
//   a left channel), synchronised into clk_50, pops one sample onto out_data. out_data then holds
//   that sample for the whole frame.
//
// Ports
//   clk_50        in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   configured    in   codec configuration done; enables frame consumption
//   daclrck       in   frame clock from the serializer (asynchronous to clk_50)
//   in_data       in   producer sample
//   in_valid      in   in_data is valid this cycle
//   in_ready      out  FIFO can accept a sample (registered)
//   out_data      out  current frame sample for the serializer
//   frame_tick    out  one-cycle pulse per consumed frame boundary
//   fill_level    out  FIFO occupancy, 0..2**DEPTH_LOG2
//   underflow     out  sticky flag: a frame boundary found the FIFO empty
//   clr_underflow in   synchronous clear of underflow
module sample_fifo_feeder #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk_50,
  input  logic                  reset,
  input  logic                  configured,
  input  logic                  daclrck,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  frame_tick,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  underflow,
  input  logic                  clr_underflow
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FullLvl = (DEPTH_LOG2 + 1)'(Depth);

  logic                  s1_q, s2_q, s3_q;
  logic [DATA_W-1:0]     mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ready_q, ready_d;
  logic [DATA_W-1:0]     out_q, out_d;
  logic                  tick_q;
  logic                  under_q, under_d;

  logic fall, pop_req, empty, push, pop;

  always_comb begin
    // s2 low while s3 still high: daclrck has been seen low for exactly one cycle past s1.
    fall    = ~s2_q & s3_q;
    pop_req = fall & configured;
    empty   = (count_q == '0);
    // ready_q already reflects a full FIFO, so a same-cycle pop never frees a slot for a push.
    push    = in_valid & ready_q;
    pop     = pop_req & ~empty;

    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push);
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    ready_d = (count_d != FullLvl);

    out_d = out_q;
    if (!configured) begin
      out_d = '0;
    end else if (pop) begin
      out_d = mem_q[rd_ptr_q];
    end

    // Setting wins over a coincident clear.
    under_d = under_q;
    if (pop_req && empty) begin
      under_d = 1'b1;
    end else if (clr_underflow) begin
      under_d = 1'b0;
    end
  end

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      out_q    <= '0;
      tick_q   <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      s1_q     <= daclrck;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      out_q    <= out_d;
      tick_q   <= pop_req;
      under_q  <= under_d;
    end
  end

  // Sample storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk_50) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign in_ready   = ready_q;
  assign out_data   = out_q;
  assign frame_tick = tick_q;
  assign fill_level = count_q;
  assign underflow  = under_q;

endmodule

// File: tb/tb_sample_fifo_feeder.sv
`timescale 1ns / 1ps
module tb_sample_fifo_feeder;

  logic        clk_50 = 1'b0;
  logic        reset;
  logic        configured;
  logic        daclrck;
  logic [23:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] out_data;
  logic        frame_tick;
  logic [4:0]  fill_level;
  logic        underflow;
  logic        clr_underflow;

  sample_fifo_feeder #(
    .DATA_W    (24),
    .DEPTH_LOG2(4)
  ) dut (
    .clk_50       (clk_50),
    .reset        (reset),
    .configured   (configured),
    .daclrck      (daclrck),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .frame_tick   (frame_tick),
    .fill_level   (fill_level),
    .underflow    (underflow),
    .clr_underflow(clr_underflow)
  );

  always #10 clk_50 = ~clk_50;

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of samples plus the daclrck values seen on the last three edges.
  logic [23:0] q [$];
  logic [23:0] m_out;
  logic        m_tick, m_under, m_ready;
  logic        d1, d2, d3;  // daclrck sampled 1, 2 and 3 edges ago

  task automatic model_reset();
    q.delete();
    m_out = '0; m_tick = 1'b0; m_under = 1'b0; m_ready = 1'b1;
    d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
  endtask

  task automatic model_edge();
    logic pop_req, push;
    // A boundary is consumed on the third edge that sees daclrck low after a high.
    pop_req = !d2 && d3 && configured;
    push    = in_valid && m_ready;
    if (!configured) m_out = '0;
    else if (pop_req && q.size() > 0) m_out = q.pop_front();
    if (pop_req && q.size() == 0 && !(m_out !== m_out)) begin end
    if (push) q.push_back(in_data);
    m_tick = pop_req;
    d3 = d2; d2 = d1; d1 = daclrck;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".out_data"},   32'(out_data),   32'(m_out));
    chk({tag, ".frame_tick"}, 32'(frame_tick), 32'(m_tick));
    chk({tag, ".fill_level"}, 32'(fill_level), 32'(q.size()));
    chk({tag, ".in_ready"},   32'(in_ready),   32'(m_ready));
    chk({tag, ".underflow"},  32'(underflow),  32'(m_under));
  endtask

  // One clock: the model sees the same pre-edge inputs as the DUT, outputs checked 1 ns later.
  task automatic step();
    @(posedge clk_50);
    if (reset) begin
      logic pop_req;
      pop_req = !d2 && d3 && configured;
      if (pop_req && q.size() == 0) m_under = 1'b1;
      else if (clr_underflow) m_under = 1'b0;
      model_edge();
      m_ready = (q.size() != 16);
    end
    #1;
    chk_all("cycle");
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One frame boundary; the pop lands inside the low half.
  task automatic lr_fall();
    daclrck = 1'b1; cyc(4);
    daclrck = 1'b0; cyc(4);
  endtask

  // Frame boundary with a push landing exactly on the pop cycle.
  task automatic coincident_push(input logic [23:0] v);
    daclrck = 1'b1; cyc(4);
    daclrck = 1'b0; step(); step();
    in_valid = 1'b1; in_data = v; step();
    in_valid = 1'b0;
    chk("coinc.frame_tick", 32'(frame_tick), 32'd1);
    cyc(1);
  endtask

  int lr_cnt;

  initial begin
    model_reset();
    reset = 1'b0; configured = 1'b0; daclrck = 1'b0;
    in_data = '0; in_valid = 1'b0; clr_underflow = 1'b0;

    // T1: reset held while inputs toggle.
    for (int i = 0; i < 6; i++) begin
      configured = i[0]; daclrck = i[1]; in_valid = 1'b1; in_data = 24'($urandom);
      clr_underflow = i[0];
      step();
    end
    chk("t1.out_data", 32'(out_data), 32'd0);
    chk("t1.fill_level", 32'(fill_level), 32'd0);
    chk("t1.in_ready", 32'(in_ready), 32'd1);
    chk("t1.underflow", 32'(underflow), 32'd0);
    in_valid = 1'b0; clr_underflow = 1'b0; daclrck = 1'b0; configured = 1'b0;
    step();
    reset = 1'b1;
    step();

    // T2: fill then drain in order.
    configured = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 24'(i); step();
    end
    in_valid = 1'b0;
    chk("t2.fill", 32'(fill_level), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      lr_fall();
      chk("t2.out_data", 32'(out_data), 32'(i));
    end
    chk("t2.underflow", 32'(underflow), 32'd0);

    // T3: overfill with no frame activity.
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_data = 24'($urandom); step();
    end
    in_valid = 1'b0;
    chk("t3.fill", 32'(fill_level), 32'd16);
    chk("t3.in_ready", 32'(in_ready), 32'd0);
    lr_fall();
    chk("t3.fill_after", 32'(fill_level), 32'd15);
    chk("t3.in_ready_after", 32'(in_ready), 32'd1);

    // T4: underflow repeats the last sample.
    for (int i = 0; i < 15; i++) lr_fall();
    in_valid = 1'b1; in_data = 24'hABCDEF; step(); in_valid = 1'b0;
    lr_fall();
    chk("t4.out_data", 32'(out_data), 32'hABCDEF);
    chk("t4.underflow_pre", 32'(underflow), 32'd0);
    lr_fall();
    chk("t4.out_hold", 32'(out_data), 32'hABCDEF);
    chk("t4.underflow", 32'(underflow), 32'd1);
    clr_underflow = 1'b1; step(); clr_underflow = 1'b0;
    chk("t4.underflow_clr", 32'(underflow), 32'd0);

    // T5: coincident push and pop.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 24'h10 + 24'(i); step();
    end
    in_valid = 1'b0;
    coincident_push(24'h13);
    chk("t5.fill", 32'(fill_level), 32'd3);
    chk("t5.out0", 32'(out_data), 32'h10);
    for (int i = 1; i <= 3; i++) begin
      lr_fall();
      chk("t5.order", 32'(out_data), 32'h10 + 32'(i));
    end
    coincident_push(24'h14);
    chk("t5.empty_under", 32'(underflow), 32'd1);
    chk("t5.empty_fill", 32'(fill_level), 32'd1);
    chk("t5.empty_out", 32'(out_data), 32'h13);

    // T6: gating while unconfigured, then reset mid-stream.
    configured = 1'b0;
    in_valid = 1'b1; in_data = 24'($urandom);
    lr_fall(); lr_fall();
    in_valid = 1'b0;
    chk("t6.out_zero", 32'(out_data), 32'd0);
    chk("t6.fill", 32'(fill_level), 32'd16);
    @(negedge clk_50);
    reset = 1'b0;
    #1;
    model_reset();
    chk_all("t6.async_reset");
    cyc(3);
    reset = 1'b1;
    step();

    // Randomized traffic against the model.
    configured = 1'b1;
    lr_cnt = 5;
    for (int i = 0; i < 3000; i++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      in_data       = 24'($urandom);
      clr_underflow = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 400) == 0) configured = ~configured;
      lr_cnt--;
      if (lr_cnt == 0) begin
        daclrck = ~daclrck;
        lr_cnt  = $urandom_range(3, 8);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
